tt_sweep_checker: RTL and testbench

- Sequential characterizer for the 4-input Cello logic netlists, such as m0x1D95.
- Drives all 16 input combinations onto the DUT inputs (in1..in4) and waits a programmable settle time per vector.
- Samples the DUT output `out` for each vector, assembles the measured 16-bit truth table, and compares it against the expected hex code.
- Sits in the verification/emulation harness as the read-back end of the netlist: the netlist implements a truth table, and this block recovers it.

---
 rtl/tt_pkg.sv | 25 ++
 rtl/tt_sweep_checker_if.sv | 33 +++
 rtl/tt_sample_vote.sv | 17 +
 rtl/tt_sweep_checker.sv | 161 ++++++++++++++++
 tb/tb_tt_sweep_checker.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/tt_pkg.sv
// tt_pkg: shared types and helpers for the truth-table sweep checker.
//   tt_state_e       : sweep FSM states
//   tt_table_t       : one measured or expected 16-entry truth table
//   TT_NUM_VEC       : number of input vectors of a 4-input netlist
//   tt_vec_to_inputs : vector index -> {in1,in2,in3,in4}
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } tt_state_e;

   typedef logic [15:0] tt_table_t;

   localparam int TT_NUM_VEC = 16;

   // in1 carries the vector MSB, in4 the LSB, so the mapping is an identity
   // on the packed nibble; kept as a function so the pin order lives in one place.
   function automatic logic [3:0] tt_vec_to_inputs(input logic [3:0] vec);
      return vec;
   endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// tt_sweep_checker_if: harness <-> checker signal bundle.
//   master : harness side (drives start, dut_out; observes stimulus and results)
//   slave  : checker side (tt_sweep_checker)
// Signals: start, dut_out, in1..in4, busy, done, table_o, pass,
//          plus glitch when TT_SWEEP_MAJORITY_EN is defined.
interface tt_sweep_checker_if;
   import tt_pkg::*;

   logic      start;
   logic      dut_out;
   logic      in1;
   logic      in2;
   logic      in3;
   logic      in4;
   logic      busy;
   logic      done;
   tt_table_t table_o;
   logic      pass;
`ifdef TT_SWEEP_MAJORITY_EN
   logic      glitch;

   modport master (output start, dut_out,
                   input  in1, in2, in3, in4, busy, done, table_o, pass, glitch);
   modport slave  (input  start, dut_out,
                   output in1, in2, in3, in4, busy, done, table_o, pass, glitch);
`else
   modport master (output start, dut_out,
                   input  in1, in2, in3, in4, busy, done, table_o, pass);
   modport slave  (input  start, dut_out,
                   output in1, in2, in3, in4, busy, done, table_o, pass);
`endif

endinterface

// File: rtl/tt_sample_vote.sv
// tt_sample_vote: 2-of-3 majority of three samples of one vector, plus a
// flag when the samples are not all equal.
//   s0, s1, s2 : the three captured samples (s2 may be the live input)
//   maj        : majority value
//   disagree   : 1 when any sample differs from the others
module tt_sample_vote (
   input  logic s0,
   input  logic s1,
   input  logic s2,
   output logic maj,
   output logic disagree
);

   assign maj      = (s0 & s1) | (s0 & s2) | (s1 & s2);
   assign disagree = (s0 ^ s1) | (s1 ^ s2);

endmodule

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: sweeps a 4-input netlist through all 16 input vectors,
// reads its output back after a settle time and compares the recovered
// truth table with EXPECTED.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tt_sweep_checker_if.slave (start, dut_out in; in1..in4,
//              busy, done, table_o, pass [, glitch] out)
// Parameters: SETTLE_CYCLES (0..255) hold cycles before sampling;
//             EXPECTED truth table, bit[v] = required output for vector v.
// Option: TT_SWEEP_MAJORITY_EN -> three samples per vector, majority vote,
//         sticky glitch flag on disagreement.
module tt_sweep_checker
   import tt_pkg::*;
#(
   parameter int        SETTLE_CYCLES = 4,
   parameter tt_table_t EXPECTED      = 16'h1D95
) (
   input  logic               clk,
   input  logic               rst,
   tt_sweep_checker_if.slave  bus
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);
   localparam logic [3:0] LAST_VEC    = 4'(TT_NUM_VEC - 1);

   tt_state_e  state_q, state_d;
   logic [3:0] vec_q;
   logic [7:0] cnt_q;
   tt_table_t  table_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;

   logic       start_ok;
   logic       hold_last;
   logic       sample_last;
   logic       sample_bit;

   // done_q high means we are in the first IDLE cycle after a sweep; a start
   // there is dropped so back-to-back requests need one clear cycle.
   assign start_ok  = bus.start && (state_q == IDLE) && !done_q;
   assign hold_last = (cnt_q == SETTLE_LAST);

`ifdef TT_SWEEP_MAJORITY_EN
   logic [1:0] sub_q;      // sample slot within SAMPLE: 0,1,2
   logic       s0_q, s1_q;
   logic       glitch_q;
   logic       vote_maj;
   logic       vote_dis;

   // Third sample is taken live so the vote lands in the same cycle.
   tt_sample_vote u_vote (
      .s0       (s0_q),
      .s1       (s1_q),
      .s2       (bus.dut_out),
      .maj      (vote_maj),
      .disagree (vote_dis)
   );

   assign sample_last = (sub_q == 2'd2);
   assign sample_bit  = vote_maj;
   assign bus.glitch  = glitch_q;
`else
   assign sample_last = 1'b1;
   assign sample_bit  = bus.dut_out;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = HOLD;
         HOLD:    if (hold_last) state_d = SAMPLE;
         SAMPLE:  if (sample_last) state_d = (vec_q == LAST_VEC) ? FINISH : HOLD;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q   <= 4'd0;
         cnt_q   <= 8'd0;
         table_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  vec_q   <= 4'd0;
                  cnt_q   <= 8'd0;
                  table_q <= '0;
                  pass_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            HOLD: cnt_q <= cnt_q + 8'd1;
            SAMPLE: begin
               if (sample_last) begin
                  table_q[vec_q] <= sample_bit;
                  // busy drops as FINISH is entered, so it covers exactly
                  // the 16 HOLD/SAMPLE vector slots.
                  if (vec_q == LAST_VEC) begin
                     busy_q <= 1'b0;
                  end else begin
                     vec_q <= vec_q + 4'd1;
                     cnt_q <= 8'd0;
                  end
               end
            end
            FINISH: begin
               done_q <= 1'b1;
               pass_q <= (table_q == EXPECTED);
            end
            default: ;
         endcase
      end
   end

`ifdef TT_SWEEP_MAJORITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         sub_q    <= 2'd0;
         s0_q     <= 1'b0;
         s1_q     <= 1'b0;
         glitch_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE:   if (start_ok) glitch_q <= 1'b0;
            HOLD:   sub_q <= 2'd0;
            SAMPLE: begin
               sub_q <= sub_q + 2'd1;
               if (sub_q == 2'd0) s0_q <= bus.dut_out;
               if (sub_q == 2'd1) s1_q <= bus.dut_out;
               if (sample_last && vote_dis) glitch_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end
`endif

   // -------------------------------------------------------------- outputs
   logic [3:0] drive;
   assign drive = ((state_q == HOLD) || (state_q == SAMPLE)) ? tt_vec_to_inputs(vec_q) : 4'b0000;
   assign {bus.in1, bus.in2, bus.in3, bus.in4} = drive;

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.table_o = table_q;
   assign bus.pass    = pass_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: two checkers (SETTLE_CYCLES=4 and 0) each reading back
// a bench-side netlist model given as a 16-bit table. Expected tables,
// pass, latency and busy width come from the sweep rules directly.
module tb_tt_sweep_checker;
   import tt_pkg::*;

`ifdef TT_SWEEP_MAJORITY_EN
   localparam int SPV = 4;   // per-vector overhead beyond SETTLE_CYCLES
`else
   localparam int SPV = 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tt_sweep_checker_if if0 ();
   tt_sweep_checker_if if1 ();

   tt_sweep_checker #(.SETTLE_CYCLES(4), .EXPECTED(16'h1D95)) u_dut0 (
      .clk (clk), .rst (rst), .bus (if0));
   tt_sweep_checker #(.SETTLE_CYCLES(0), .EXPECTED(16'h1D95)) u_dut1 (
      .clk (clk), .rst (rst), .bus (if1));

   logic       start_r [2];
   tt_table_t  tbl     [2];
   bit         flip;            // inverts dut0's netlist output this cycle
   logic       busy_w  [2];
   logic       done_w  [2];
   logic       pass_w  [2];
   tt_table_t  tab_w   [2];
   logic [3:0] inv_w   [2];
   logic       glt_w   [2];

   assign if0.start   = start_r[0];
   assign if1.start   = start_r[1];
   assign inv_w[0]    = {if0.in1, if0.in2, if0.in3, if0.in4};
   assign inv_w[1]    = {if1.in1, if1.in2, if1.in3, if1.in4};
   assign if0.dut_out = tbl[0][inv_w[0]] ^ flip;
   assign if1.dut_out = tbl[1][inv_w[1]];
   assign busy_w[0] = if0.busy;    assign busy_w[1] = if1.busy;
   assign done_w[0] = if0.done;    assign done_w[1] = if1.done;
   assign pass_w[0] = if0.pass;    assign pass_w[1] = if1.pass;
   assign tab_w[0]  = if0.table_o; assign tab_w[1]  = if1.table_o;
`ifdef TT_SWEEP_MAJORITY_EN
   assign glt_w[0] = if0.glitch;   assign glt_w[1] = if1.glitch;
`else
   assign glt_w[0] = 1'b0;         assign glt_w[1] = 1'b0;
`endif

   int n_vec = 0;
   int n_err = 0;
   int lat, busy_cnt, done_cnt;
   int seq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int settle_of(input int d);
      return (d == 0) ? 4 : 0;
   endfunction

   // One sweep on checker d reading back table t. Returns at the cycle right
   // after done (or after a bounded timeout, leaving lat = -1).
   task automatic sweep(input int d, input tt_table_t t, input bit spam, input int flip_k);
      int k;
      int exp_lat;
      exp_lat  = 16 * (settle_of(d) + SPV) + 1;
      tbl[d]   = t;
      lat      = -1;
      busy_cnt = 0;
      done_cnt = 0;
      seq.delete();
      @(negedge clk);
      start_r[d] = 1'b1;
      @(posedge clk);
      #1;
      start_r[d] = 1'b0;
      k = 0;
      flip = (d == 0) && (flip_k == 0);
      while (k <= exp_lat + 8) begin
         @(negedge clk);
         if (k == 0) begin
            chk("accept_busy", busy_w[d], 1'b1);
            chk("accept_pass_clr", pass_w[d], 1'b0);
            chk("accept_tab_clr", tab_w[d], 16'h0);
         end
         if (busy_w[d]) begin
            busy_cnt++;
            if (seq.size() == 0 || seq[$] != int'(inv_w[d])) seq.push_back(int'(inv_w[d]));
         end
         if (done_w[d]) begin
            done_cnt++;
            if (lat < 0) lat = k;
         end
         start_r[d] = spam && ((k % 3 == 1) || k == exp_lat - 1 || k == exp_lat);
         @(posedge clk);
         #1;
         k++;
         flip = (d == 0) && (k == flip_k);
         if (lat >= 0 && k > lat) break;
      end
      start_r[d] = 1'b0;
      flip = 1'b0;
   endtask

   // Sweep plus all checks derived from the read-back rules.
   task automatic verify(input string tag, input int d, input tt_table_t t,
                         input bit spam, input int flip_k);
      int s;
      bit ord;
      s = settle_of(d);
      sweep(d, t, spam, flip_k);
      ord = (seq.size() == 16);
      foreach (seq[i]) if (seq[i] != i) ord = 1'b0;
      chk({tag, "_latency"}, lat, 16 * (s + SPV) + 1);
      chk({tag, "_busy_cycles"}, busy_cnt, 16 * (s + SPV));
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_vec_order"}, ord, 1'b1);
      chk({tag, "_table"}, tab_w[d], t);
      chk({tag, "_pass"}, pass_w[d], (t == 16'h1D95));
`ifdef TT_SWEEP_MAJORITY_EN
      chk({tag, "_glitch"}, glt_w[d], (flip_k >= 0));
`endif
   endtask

   task automatic chk_reset(input string tag, input int d);
      chk({tag, "_in"},    inv_w[d],  4'h0);
      chk({tag, "_busy"},  busy_w[d], 1'b0);
      chk({tag, "_done"},  done_w[d], 1'b0);
      chk({tag, "_table"}, tab_w[d],  16'h0);
      chk({tag, "_pass"},  pass_w[d], 1'b0);
      chk({tag, "_glitch"}, glt_w[d], 1'b0);
   endtask

   initial begin
      tt_table_t r;
      tt_table_t hold_t;
      int n_done;
      start_r[0] = 1'b0;
      start_r[1] = 1'b0;
      tbl[0] = 16'h1D95;
      tbl[1] = 16'h1D95;
      flip = 1'b0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset("rst0", 0);
      chk_reset("rst1", 1);

      // Reference netlist, then single-input functions.
      verify("m1D95", 0, 16'h1D95, 1'b0, -1);
      verify("in4", 0, 16'hAAAA, 1'b0, -1);
      verify("in1", 0, 16'hFF00, 1'b0, -1);

      // Zero settle, constant 1; then check results hold while idle.
      verify("ones_s0", 1, 16'hFFFF, 1'b0, -1);
      hold_t = tab_w[1];
      repeat (6) @(negedge clk);
      chk("hold_table", tab_w[1], hold_t);
      chk("hold_pass", pass_w[1], 1'b0);
      verify("m1D95_s0", 1, 16'h1D95, 1'b0, -1);

      // Random netlists.
      for (int i = 0; i < 4; i++) begin
         r = 16'($urandom);
         verify("rand_s0", 1, r, 1'b0, -1);
      end
      r = 16'($urandom);
      verify("rand_s4", 0, r, 1'b0, -1);

      // Start spam during busy, FINISH and the done cycle, then a start on
      // the very next cycle (pass must clear on acceptance).
      verify("spam", 0, 16'h1D95, 1'b1, -1);
      r = 16'($urandom);
      verify("b2b", 0, r, 1'b0, -1);

`ifdef TT_SWEEP_MAJORITY_EN
      // Invert the middle sample of vector 3; the vote hides it, glitch sets.
      verify("maj_flip", 0, 16'h1D95, 1'b0, 3 * (4 + SPV) + 4 + 2);
`endif

      // Reset in the middle of HOLD for vector 7.
      tbl[0] = 16'h1D95;
      @(negedge clk);
      start_r[0] = 1'b1;
      @(posedge clk);
      #1;
      start_r[0] = 1'b0;
      repeat (7 * (4 + SPV) + 1) @(posedge clk);
      @(negedge clk);
      chk("midrst_vec", inv_w[0], 4'd7);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_reset("midrst", 0);
      n_done = 0;
      repeat (16 * (4 + SPV) + 10) begin
         @(negedge clk);
         if (done_w[0]) n_done++;
      end
      chk("midrst_no_done", n_done, 0);
      r = 16'($urandom);
      verify("after_rst", 0, r, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
